mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line data width in bits, a power of two and at least 8.
REQ-003 SHALL have parameter DEPTH, default 256, number of stored lines, a power of two.
REQ-004 SHALL have parameter READ_LAT, default 4, read latency in cycles, at least 1.
REQ-005 SHALL have parameter WRITE_LAT, default 2, write busy time in cycles, at least 1.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port req_valid_mem, input, 1 bit: initiator has a request.
REQ-009 SHALL have port req_ready_mem, output, 1 bit: responder can accept a request.
REQ-010 SHALL have port read_en_mem, input, 1 bit: the request is a line read.
REQ-011 SHALL have port write_en_mem, input, 1 bit: the request is a line write-back.
REQ-012 SHALL have port addr, input, ADDR_W bits: byte address of the line.
REQ-013 SHALL have port wdata_line, input, LINE_W bits: write-back line data.
REQ-014 SHALL have port resp_valid_mem, output, 1 bit: rdata_line holds valid read data.
REQ-015 SHALL have port resp_ready_mem, input, 1 bit: initiator accepts the response.
REQ-016 SHALL have port rdata_line, output, LINE_W bits: read line data.
REQ-017 SHALL have port proto_err, output, 1 bit: sticky flag for a protocol violation.

Function
REQ-018 SHALL implement the states IDLE, WRITE_BUSY, READ_WAIT and RESP.
REQ-019 SHALL drive req_ready_mem to 1 only in IDLE.
REQ-020 SHALL drive resp_valid_mem to 1 only in RESP.
REQ-021 SHALL accept a request on a rising edge where req_valid_mem=1 and req_ready_mem=1; this edge is called E0.
REQ-022 SHALL sample read_en_mem, write_en_mem, addr and wdata_line only at E0.
REQ-023 SHALL compute the line index as addr[OFF +: log2(DEPTH)], where OFF=log2(LINE_W/8); upper address bits are ignored and wrap modulo DEPTH.
REQ-024 SHALL, on an accepted write (write_en_mem=1), store wdata_line at the line index at E0 and enter WRITE_BUSY.
REQ-025 SHALL return from WRITE_BUSY to IDLE at edge E0+WRITE_LAT, and SHALL produce no response for a write.
REQ-026 SHALL, on an accepted read (read_en_mem=1, write_en_mem=0), capture the stored line into rdata_line at E0 and enter READ_WAIT with a down-counter of width clog2(READ_LAT)+1 loaded with READ_LAT-1.
REQ-027 SHALL, in READ_WAIT, go to RESP when the counter is 0 and otherwise decrement it, so that resp_valid_mem rises at edge E0+READ_LAT.
REQ-028 SHALL hold resp_valid_mem and rdata_line stable in RESP until an edge with resp_ready_mem=1, then return to IDLE.
REQ-029 SHALL accept no new request in the cycle in which RESP exits; req_ready_mem rises on the following cycle.
REQ-030 SHALL, if read_en_mem=1 and write_en_mem=1 at E0, perform the write only and set proto_err.
REQ-031 SHALL, if neither read_en_mem nor write_en_mem is set at E0, perform no operation, stay in IDLE and set proto_err.
REQ-032 SHALL, once proto_err is set, hold it until reset.
REQ-033 SHALL ignore resp_ready_mem outside RESP.
REQ-034 SHALL ignore changes on the request inputs outside E0.
REQ-035 SHALL give a read of a line written at an earlier edge the newly written data.

Reset
REQ-036 SHALL, on rst=1 at any time, go immediately to IDLE with resp_valid_mem=0, proto_err=0, rdata_line=0 and the counter at 0.
REQ-037 SHALL assert req_ready_mem=1 on the first cycle after rst is released.
REQ-038 SHALL discard a pending read or response on reset, with no response after reset.
REQ-039 SHALL leave stored line contents unchanged by reset.

Verification
REQ-040 SHALL be verified by a write-then-read scenario: write addr 0x40, data 0xDEADBEEF_00000001_CAFEF00D_12345678; then read 0x40 -> resp_valid_mem rises 4 edges after the read E0, with the same data.
REQ-041 SHALL be verified by a backpressure scenario: hold resp_ready_mem=0 for 5 cycles in RESP -> resp_valid_mem stays 1, rdata_line is stable and req_ready_mem=0; resp_ready_mem=1 -> IDLE one edge later.
REQ-042 SHALL be verified by a wrap scenario: write to addr 0x1000, then read from addr 0x0 -> the same line is returned (index 0, DEPTH=256, LINE_W=128).
REQ-043 SHALL be verified by a write-back/allocate scenario: write E0, with req_valid_mem held high -> req_ready_mem=0 for exactly 2 cycles, then the read is accepted.
REQ-044 SHALL be verified by a protocol-error scenario: a handshake with both enables set -> write performed, no response, proto_err=1 until rst.
REQ-045 SHALL be verified by a reset-mid-read scenario: assert rst 2 cycles after the read E0 -> resp_valid_mem never rises and req_ready_mem=1 after release.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Line-granular memory responder for a cache refill / write-back port.
// One request is handled at a time through a valid/ready handshake:
//   * A write stores the whole line at the handshake edge. The responder then
//     stays busy for WRITE_LAT cycles and gives no response.
//   * A read captures the stored line at the handshake edge. It then presents
//     it on rdata_line with resp_valid_mem, READ_LAT edges later, and holds it
//     until the initiator takes it with resp_ready_mem.
//   * A request with both enables set is treated as a write. A request with
//     neither enable set is dropped. Both cases raise the sticky proto_err.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous, active-high reset (line storage is kept)
//   req_valid_mem   initiator has a request
//   req_ready_mem   responder can accept a request (high only when idle)
//   read_en_mem     request is a line read
//   write_en_mem    request is a line write-back
//   addr            byte address; line index = addr[OFF +: log2(DEPTH)]
//   wdata_line      write-back line data
//   resp_valid_mem  rdata_line holds valid read data
//   resp_ready_mem  initiator accepts the response
//   rdata_line      read line data
//   proto_err       sticky protocol-violation flag, cleared only by rst

module mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_mem,
    output logic              req_ready_mem,
    input  logic              read_en_mem,
    input  logic              write_en_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata_line,
    output logic              resp_valid_mem,
    input  logic              resp_ready_mem,
    output logic [LINE_W-1:0] rdata_line,
    output logic              proto_err
);

    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RCNT_W = $clog2(READ_LAT) + 1;
    localparam int WCNT_W = $clog2(WRITE_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BUSY = 2'd1,
        READ_WAIT  = 2'd2,
        RESP       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                perr_q, perr_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;

    // Line storage. It has no reset, so its contents survive rst.
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                do_write;
    logic                unused_addr;

    // Upper address bits wrap modulo DEPTH, and the byte-offset bits are
    // don't-care. Both are folded here so that every address bit is read.
    assign unused_addr = ^addr;

    assign idx      = addr[OFF +: IDX_W];
    assign accept   = req_valid_mem & ready_q;
    assign do_write = accept & write_en_mem;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[idx] <= wdata_line;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (write_en_mem) begin
                        // A write takes priority. If read was also requested,
                        // the read is dropped and flagged.
                        state_d = WRITE_BUSY;
                        wcnt_d  = WCNT_W'(WRITE_LAT - 1);
                        if (read_en_mem) begin
                            perr_d = 1'b1;
                        end
                    end else if (read_en_mem) begin
                        state_d = READ_WAIT;
                        rcnt_d  = RCNT_W'(READ_LAT - 1);
                        rdata_d = mem_q[idx];
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            WRITE_BUSY: begin
                if (wcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            READ_WAIT: begin
                if (rcnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_mem) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The handshake outputs are registered copies of the next state.
        // Because of that, req_ready_mem only rises in the cycle after RESP
        // has been left.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign req_ready_mem  = ready_q;
    assign resp_valid_mem = valid_q;
    assign rdata_line     = rdata_q;
    assign proto_err      = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// ----------------
// Self-checking bench for mem_responder.
// The reference model is a plain array of lines, indexed by
// (addr / bytes_per_line) % DEPTH. Latencies are expected as fixed edge
// counts measured from the handshake edge.

`timescale 1ns/1ps

module tb_mem_responder;

    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 128;
    localparam int DEPTH      = 256;
    localparam int READ_LAT   = 4;
    localparam int WRITE_LAT  = 2;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int BOUND      = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_mem = 1'b0;
    logic              req_ready_mem;
    logic              read_en_mem = 1'b0;
    logic              write_en_mem = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LINE_W-1:0] wdata_line = '0;
    logic              resp_valid_mem;
    logic              resp_ready_mem = 1'b0;
    logic [LINE_W-1:0] rdata_line;
    logic              proto_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [LINE_W-1:0] model_mem [DEPTH];
    bit                model_written [DEPTH];

    mem_responder #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_mem (req_valid_mem),
        .req_ready_mem (req_ready_mem),
        .read_en_mem   (read_en_mem),
        .write_en_mem  (write_en_mem),
        .addr          (addr),
        .wdata_line    (wdata_line),
        .resp_valid_mem(resp_valid_mem),
        .resp_ready_mem(resp_ready_mem),
        .rdata_line    (rdata_line),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    function automatic int model_index(input logic [ADDR_W-1:0] a);
        return int'((a / LINE_BYTES) % DEPTH);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one request and waits (bounded) for the handshake edge.
    // It returns at handshake edge + 1ns with the request inputs scrambled,
    // because they must be ignored outside the handshake edge.
    task automatic issue(input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        int n;
        n = 0;
        req_valid_mem = 1'b1;
        read_en_mem   = rd;
        write_en_mem  = wr;
        addr          = a;
        wdata_line    = d;
        while (req_ready_mem !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= BOUND) begin
            n_errors++;
            $display("FAIL issue_timeout: req_ready_mem=%b required 1", req_ready_mem);
        end
        @(posedge clk); #1;
        if (wr) begin
            model_mem[model_index(a)]     = d;
            model_written[model_index(a)] = 1'b1;
        end
        $display("txn rd=%0d wr=%0d addr=%h idx=%0d data=%h", rd, wr, a, model_index(a), d);
        req_valid_mem = 1'b0;
        read_en_mem   = 1'($urandom_range(0, 1));
        write_en_mem  = 1'($urandom_range(0, 1));
        addr          = $urandom();
        wdata_line    = rand_line();
    endtask

    // Counts the edges until resp_valid_mem is seen. While waiting,
    // resp_ready_mem is toggled, because it must be ignored outside RESP.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid_mem !== 1'b1 && lat < BOUND) begin
            resp_ready_mem = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        resp_ready_mem = 1'b0;
    endtask

    // Counts the cycles where req_ready_mem is low, starting at the current sample.
    task automatic count_busy(output int busy);
        busy = 0;
        while (req_ready_mem !== 1'b1 && busy < BOUND) begin
            @(posedge clk); #1;
            busy++;
        end
    endtask

    task automatic finish_resp();
        resp_ready_mem = 1'b1;
        @(posedge clk); #1;
        resp_ready_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (req_ready_mem !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b required 1", req_ready_mem);
        end
        n_checks++;
        if (resp_valid_mem !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b required 0", resp_valid_mem);
        end
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_proto_err: got %b required 0", proto_err);
        end
        n_checks++;
        if (rdata_line !== '0) begin
            n_errors++; $display("FAIL reset_rdata: got %h required 0", rdata_line);
        end
    endtask

    task automatic test_write_read();
        logic [LINE_W-1:0] d;
        int busy, lat;
        d = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
        issue(1'b0, 1'b1, 32'h40, d);
        count_busy(busy);
        n_checks++;
        if (busy != WRITE_LAT) begin
            n_errors++; $display("FAIL write_busy: got %0d cycles required %0d", busy, WRITE_LAT);
        end
        issue(1'b1, 1'b0, 32'h40, '0);
        wait_resp(lat);
        n_checks++;
        if (lat != READ_LAT) begin
            n_errors++; $display("FAIL read_latency: got %0d edges required %0d", lat, READ_LAT);
        end
        n_checks++;
        if (rdata_line !== d) begin
            n_errors++; $display("FAIL write_read_data: got %h required %h", rdata_line, d);
        end
        finish_resp();
        n_checks++;
        if (resp_valid_mem !== 1'b0 || req_ready_mem !== 1'b1) begin
            n_errors++;
            $display("FAIL resp_exit: valid=%b ready=%b required valid=0 ready=1", resp_valid_mem, req_ready_mem);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int lat, bad;
        a = 32'h0000_0230;
        d = rand_line();
        issue(1'b0, 1'b1, a, d);
        issue(1'b1, 1'b0, a, '0);
        wait_resp(lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid_mem !== 1'b1 || rdata_line !== d || req_ready_mem !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0 || resp_valid_mem !== 1'b1 || rdata_line !== d) begin
            n_errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d valid=%b data=%h required 0 bad, valid=1 data=%h",
                     bad, resp_valid_mem, rdata_line, d);
        end
        finish_resp();
        n_checks++;
        if (resp_valid_mem !== 1'b0) begin
            n_errors++; $display("FAIL backpressure_release: valid=%b required 0", resp_valid_mem);
        end
    endtask

    task automatic test_wrap();
        logic [LINE_W-1:0] d;
        int lat;
        d = rand_line();
        issue(1'b0, 1'b1, 32'h1000, d);
        issue(1'b1, 1'b0, 32'h0, '0);
        wait_resp(lat);
        n_checks++;
        if (lat != READ_LAT || rdata_line !== d) begin
            n_errors++;
            $display("FAIL wrap_read: lat=%0d data=%h required lat=%0d data=%h", lat, rdata_line, READ_LAT, d);
        end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int zeros, lat;
        a = 32'h0000_0570;
        d = rand_line();
        req_valid_mem = 1'b1;
        write_en_mem  = 1'b1;
        read_en_mem   = 1'b0;
        addr          = a;
        wdata_line    = d;
        @(posedge clk); #1;
        model_mem[model_index(a)]     = d;
        model_written[model_index(a)] = 1'b1;
        $display("txn rd=0 wr=1 addr=%h held-valid", a);
        write_en_mem = 1'b0;
        read_en_mem  = 1'b1;
        count_busy(zeros);
        n_checks++;
        if (zeros != WRITE_LAT) begin
            n_errors++; $display("FAIL b2b_ready_low: got %0d cycles required %0d", zeros, WRITE_LAT);
        end
        @(posedge clk); #1;
        $display("txn rd=1 wr=0 addr=%h held-valid", a);
        req_valid_mem = 1'b0;
        wait_resp(lat);
        n_checks++;
        if (lat != READ_LAT || rdata_line !== d) begin
            n_errors++;
            $display("FAIL b2b_read: lat=%0d data=%h required lat=%0d data=%h", lat, rdata_line, READ_LAT, d);
        end
        finish_resp();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int busy, lat, idx, stall;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom() & 32'hFFFF_F00F) | (32'($urandom_range(0, 15)) << 4);
            idx = model_index(a);
            if ($urandom_range(0, 1) == 1 || !model_written[idx]) begin
                d = rand_line();
                issue(1'b0, 1'b1, a, d);
                count_busy(busy);
                n_checks++;
                if (busy != WRITE_LAT) begin
                    n_errors++; $display("FAIL rand_write_busy: got %0d required %0d", busy, WRITE_LAT);
                end
            end else begin
                issue(1'b1, 1'b0, a, '0);
                wait_resp(lat);
                stall = $urandom_range(0, 3);
                repeat (stall) begin
                    @(posedge clk); #1;
                end
                n_checks++;
                if (lat != READ_LAT || rdata_line !== model_mem[idx] || resp_valid_mem !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_read idx=%0d: lat=%0d valid=%b data=%h required lat=%0d valid=1 data=%h",
                             idx, lat, resp_valid_mem, rdata_line, READ_LAT, model_mem[idx]);
                end
                finish_resp();
            end
        end
    endtask

    task automatic test_proto_err();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int busy, lat, seen;
        a = 32'h0000_0A90;
        d = rand_line();
        issue(1'b1, 1'b1, a, d);
        seen = 0;
        for (int i = 0; i < READ_LAT + 4; i++) begin
            if (resp_valid_mem === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++; $display("FAIL proto_no_resp: valid seen %0d cycles required 0", seen);
        end
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_errors++; $display("FAIL proto_err_set: got %b required 1", proto_err);
        end
        issue(1'b1, 1'b0, a, '0);
        wait_resp(lat);
        n_checks++;
        if (lat != READ_LAT || rdata_line !== d) begin
            n_errors++;
            $display("FAIL proto_write_done: lat=%0d data=%h required lat=%0d data=%h", lat, rdata_line, READ_LAT, d);
        end
        finish_resp();
        issue(1'b0, 1'b0, a, rand_line());
        n_checks++;
        if (req_ready_mem !== 1'b1 || proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL proto_noop: ready=%b perr=%b required ready=1 perr=1", req_ready_mem, proto_err);
        end
        count_busy(busy);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++; $display("FAIL proto_err_clear: got %b required 0", proto_err);
        end
        issue(1'b1, 1'b0, a, '0);
        wait_resp(lat);
        n_checks++;
        if (rdata_line !== d) begin
            n_errors++; $display("FAIL reset_keeps_mem: got %h required %h", rdata_line, d);
        end
        finish_resp();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        issue(1'b1, 1'b0, 32'h40, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (resp_valid_mem !== 1'b0 || rdata_line !== '0) begin
            n_errors++;
            $display("FAIL mid_read_reset: valid=%b data=%h required valid=0 data=0", resp_valid_mem, rdata_line);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (req_ready_mem !== 1'b1) begin
            n_errors++; $display("FAIL mid_read_ready: got %b required 1", req_ready_mem);
        end
        seen = 0;
        for (int i = 0; i < READ_LAT + 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid_mem === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++; $display("FAIL mid_read_no_resp: valid seen %0d cycles required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_random();
        test_proto_err();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
